branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 69 ++++++
 tb/tb_branch_resolve_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-stage branch resolver with wrong-path squash and saturating perf counters
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic             stall,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    logic             valid_q, taken_q, mispredict_q, illegal_q;
    logic             valid_d, taken_d, mispredict_d, illegal_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;
    logic             legal, cond, fire;
    always_comb begin
        legal        = in_funct3[2:1] != 2'b01;
        cond         = (in_funct3[2] ? (in_funct3[1] ? in_rs1 < in_rs2 : $signed(in_rs1) < $signed(in_rs2))
                                     : in_rs1 == in_rs2) ^ in_funct3[0];
        // a mispredict on the output means the incoming instruction is wrong-path
        fire         = in_valid & ~mispredict_q;
        valid_d      = fire;
        illegal_d    = fire & ~legal;
        taken_d      = fire & legal & cond;
        mispredict_d = fire & legal & (cond ^ in_pred_taken);
        redirect_d   = in_pc + (taken_d ? in_imm : XLEN'(4));
        bc_d         = bc_q + CNT_W'(valid_q & ~illegal_q & ~(&bc_q));
        mc_d         = mc_q + CNT_W'(mispredict_q & ~(&mc_q));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            redirect_q   <= '0;
            bc_q         <= '0;
            mc_q         <= '0;
        end else if (!stall) begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            redirect_q   <= redirect_d;
            bc_q         <= bc_d;
            mc_q         <= mc_d;
        end
    end
    assign out_valid        = valid_q;
    assign out_taken        = taken_q;
    assign out_mispredict   = mispredict_q;
    assign out_illegal      = illegal_q;
    assign out_redirect_pc  = redirect_q;
    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors plus a spec-level model checked every cycle
module tb_branch_resolve_unit;
    logic        clk = 0, reset = 1, in_valid = 0, in_pred_taken = 0, stall = 0;
    logic [2:0]  in_funct3 = 0;
    logic [31:0] in_rs1 = 0, in_rs2 = 0, in_pc = 0, in_imm = 0;
    logic        ov, ot, om, oi, ov4, ot4, om4, oi4;
    logic [31:0] orp, orp4;
    logic [15:0] bc, mc;
    logic [3:0]  bc4, mc4;
    int          total = 0, passed = 0;
    bit          run = 0;
    bit          m_v, m_t, m_m, m_i;
    logic [31:0] m_pc;
    int          m_bc, m_mc, m_bc4, m_mc4;
    always #5 clk = ~clk;
    branch_resolve_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken), .stall(stall),
        .out_valid(ov), .out_taken(ot), .out_mispredict(om), .out_illegal(oi), .out_redirect_pc(orp),
        .branch_count(bc), .mispredict_count(mc));
    branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken), .stall(stall),
        .out_valid(ov4), .out_taken(ot4), .out_mispredict(om4), .out_illegal(oi4), .out_redirect_pc(orp4),
        .branch_count(bc4), .mispredict_count(mc4));
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask
    function automatic bit outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction
    always @(posedge clk) begin
        if (reset) begin
            {m_v, m_t, m_m, m_i} = 0;
            m_pc = 0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else if (!stall) begin
            if (m_v && !m_i) begin
                m_bc  = (m_bc  < 65535) ? m_bc + 1  : m_bc;
                m_bc4 = (m_bc4 < 15)    ? m_bc4 + 1 : m_bc4;
            end
            if (m_m) begin
                m_mc  = (m_mc  < 65535) ? m_mc + 1  : m_mc;
                m_mc4 = (m_mc4 < 15)    ? m_mc4 + 1 : m_mc4;
            end
            m_v  = in_valid && !m_m;
            m_i  = m_v && (in_funct3 == 3'd2 || in_funct3 == 3'd3);
            m_t  = m_v && !m_i && outcome(in_funct3, in_rs1, in_rs2);
            m_m  = m_v && !m_i && (m_t != in_pred_taken);
            m_pc = m_t ? in_pc + in_imm : in_pc + 32'd4;
        end
    end
    always @(negedge clk) if (run) begin
        chk("m_valid", ov, m_v);
        chk("m_mispredict", om, m_m);
        chk("m_illegal", oi, m_i);
        chk("m_bc", bc, m_bc);
        chk("m_mc", mc, m_mc);
        chk("m_bc4", bc4, m_bc4);
        chk("m_mc4", mc4, m_mc4);
        if (m_v) begin
            chk("m_taken", ot, m_t);
            chk("m_redirect", orp, m_pc);
        end
    end
    task automatic cyc(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic p, input logic st,
                       input logic rs);
        in_valid = v; in_funct3 = f; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
        in_pred_taken = p; stall = st; reset = rs;
        @(negedge clk);
    endtask
    task automatic bub(input logic st);
        cyc(0, 0, 0, 0, 0, 0, 0, st, 0);
    endtask
    initial begin
        @(negedge clk);
        cyc(1, 0, 1, 1, 32'h10, 32'h8, 0, 0, 1);
        run = 1;
        chk("reset_valid", ov, 0);
        chk("reset_redirect", orp, 0);
        chk("reset_bc", bc, 0);
        bub(0);
        chk("post_reset_valid", ov, 0);
        cyc(1, 3'd4, 32'hFFFFFFFF, 1, 32'h100, 32'h20, 1, 0, 0);
        chk("blt_taken", ot, 1);
        chk("blt_redirect", orp, 32'h120);
        chk("blt_mispredict", om, 0);
        cyc(1, 3'd6, 32'hFFFFFFFF, 1, 32'h100, 32'h20, 1, 0, 0);
        chk("bltu_taken", ot, 0);
        chk("bltu_mispredict", om, 1);
        chk("bltu_redirect", orp, 32'h104);
        bub(0);
        chk("bc_after_blt", bc, 2);
        chk("mc_after_bltu", mc, 1);
        cyc(1, 3'd0, 5, 5, 32'h200, 32'h40, 0, 0, 0);
        chk("beq_mispredict", om, 1);
        chk("beq_redirect", orp, 32'h240);
        cyc(1, 3'd1, 5, 6, 32'h204, 32'h40, 1, 0, 0);
        chk("squash_valid", ov, 0);
        chk("squash_mispredict", om, 0);
        bub(0);
        chk("squash_bc", bc, 3);
        chk("squash_mc", mc, 2);
        cyc(1, 3'd0, 1, 2, 32'h300, 32'h40, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd1, 1, 2, 32'h800, 32'h40, 0, 1, 0);
            chk("stall_mispredict", om, 1);
            chk("stall_redirect", orp, 32'h304);
            chk("stall_mc", mc, 2);
        end
        bub(0);
        chk("stall_release_mc", mc, 3);
        chk("stall_release_bc", bc, 4);
        cyc(1, 3'd2, 7, 7, 32'h400, 32'h40, 1, 0, 0);
        chk("illegal_flag", oi, 1);
        chk("illegal_taken", ot, 0);
        chk("illegal_redirect", orp, 32'h404);
        bub(0);
        chk("illegal_bc", bc, 4);
        chk("illegal_mc", mc, 3);
        cyc(1, 3'd0, 1, 2, 32'hFFFFFFFC, 32'h8, 0, 0, 0);
        chk("wrap_redirect", orp, 32'h0);
        for (int i = 0; i < 20; i++) cyc(1, 3'd1, 1, 2, 32'h500, 32'h10, 1, 0, 0);
        bub(0);
        chk("sat_bc4", bc4, 15);
        chk("bc_25", bc, 25);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ops [4];
            logic [2:0]  fs [7];
            ops = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF};
            fs  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
            cyc($urandom_range(0, 3) != 0, fs[$urandom_range(0, 6)], ops[$urandom_range(0, 3)],
                ops[$urandom_range(0, 3)], $urandom, $urandom, $urandom_range(0, 1),
                $urandom_range(0, 3) == 0, 0);
        end
        bub(0);
        cyc(1, 3'd0, 3, 3, 32'h600, 32'h20, 1, 0, 0);
        chk("pre_reset_valid", ov, 1);
        cyc(1, 3'd0, 3, 3, 32'h700, 32'h20, 1, 1, 1);
        chk("rst_valid", ov, 0);
        chk("rst_taken", ot, 0);
        chk("rst_redirect", orp, 0);
        chk("rst_bc", bc, 0);
        chk("rst_mc", mc, 0);
        chk("rst_bc4", bc4, 0);
        bub(0);
        chk("rst_after_valid", ov, 0);
        run = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
